uart_rx_sink: RTL and testbench
===============================

UART_RX_SINK -- requirements
Module: uart_rx_sink

Interface
REQ-001 CLK_DIV, default 868, clock cycles per UART bit (100 MHz / 115200 baud); legal range 4..65535.
REQ-002 FIFO_DEPTH, default 8, receive buffer entries; must be a power of two, at least 2.
REQ-003 clk_i  in  1  system clock; all logic is on the rising edge.
REQ-004 rst_ni  in  1  reset, asynchronous and active-low.
REQ-005 rx_i  in  1  serial line from the DUT tx pin; idle high; asynchronous to clk_i.
REQ-006 data_o  out  8  byte at the FIFO head.
REQ-007 valid_o  out  1  data_o is valid.
REQ-008 ready_i  in  1  consumer accepts data_o; a pop occurs when valid_o and ready_i are both high.
REQ-009 frame_err_o  out  1  one-cycle pulse when the sampled stop bit is 0.
REQ-010 parity_err_o  out  1  one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.
REQ-011 overrun_o  out  1  one-cycle pulse when a completed byte is dropped because the FIFO is full.
REQ-012 fill_o  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
REQ-013 busy_o  out  1  high in every FSM state except IDLE.

Function
REQ-014 rx_i passes through a 2-flop synchronizer; all later references to rx mean the synchronized value.
REQ-015 FSM states: ARM, IDLE, START, DATA, PARITY, STOP.
REQ-016 ARM: wait for rx=1, then move to IDLE.
REQ-017 IDLE: on an rx falling edge (previous cycle 1, current cycle 0), load the bit counter with CLK_DIV/2 (integer division) and move to START.
REQ-018 START: when the bit counter expires, sample rx.
  - rx=0: move to DATA.
  - rx=1: false start; move to IDLE with no output and no error.
REQ-019 DATA: sample 8 bits, LSB first, one every CLK_DIV cycles at mid-bit; after bit 7, move to PARITY if parity is enabled, otherwise to STOP.
REQ-020 STOP: sample rx at mid-bit.
  - rx=1: push the byte.
  - rx=0: pulse frame_err_o, discard the byte, move to ARM (line-break handling).
REQ-021 A valid stop bit returns the FSM to IDLE on the cycle after the sample, so a start edge that immediately follows the stop bit is not missed.
REQ-022 After a push, valid_o rises on the cycle after the stop-bit sample cycle (latency 1).
REQ-023 Push while full:
  - With a simultaneous pop: the push is accepted and fill_o is unchanged.
  - Without a pop: the byte is dropped, overrun_o pulses, and the FIFO contents are unchanged.
REQ-024 Pop while empty has no effect; fill_o never wraps below 0.
REQ-025 data_o and valid_o hold stable while valid_o=1 and ready_i=0.
REQ-026 The FIFO read and write pointers wrap modulo FIFO_DEPTH.
REQ-027 The bit counter is a 16-bit down-counter; reload value is CLK_DIV-1.

Reset
REQ-028 Asserting rst_ni at any time, including mid-frame, aborts the frame and clears the FIFO.
REQ-029 Output values during reset: valid_o=0, fill_o=0, all error pulses 0, busy_o=0, data_o=0.
REQ-030 The FSM resets to ARM and the synchronizer flops reset to 1.
REQ-031 A line held low across reset release produces no byte and no error until rx has been seen high.

Configuration
REQ-032 UART_RX_PARITY_EN defined:
  - The PARITY state samples one even-parity bit at mid-bit.
  - On a mismatch, parity_err_o pulses, the byte is discarded, and the stop bit is still checked.
REQ-033 UART_RX_PARITY_EN undefined: the PARITY state and its logic are removed and parity_err_o is constant 0.

Structure
REQ-034 Shared package uart_rx_pkg holds:
  - the FSM state typedef;
  - the CLK_DIV_DEFAULT constant (868);
  - the DATA_BITS constant (8).
REQ-035 The FIFO is a separate sub-module, uart_rx_fifo, with push/pop/full/empty/fill ports; the FSM and counters stay in uart_rx_sink.

Verification
REQ-036 Bench parameters are CLK_DIV=16 and FIFO_DEPTH=4 for every scenario below.
REQ-037 Frames 0x55, then 0xA3 back to back with ready_i=1 -> two pops of 0x55 then 0xA3, no error pulses, valid_o rises 1 cycle after each stop sample.
REQ-038 rx low for 5 cycles, then high -> false start: no byte, no error pulse, FSM returns to IDLE.
REQ-039 Frame 0x3C with a stop bit of 0, rx then held low 200 cycles, then frame 0x81 -> frame_err_o pulses once; the only byte out is 0x81.
REQ-040 ready_i=0 and frames 0x01..0x05 sent -> fill_o reaches 4, overrun_o pulses on 0x05, later pops return 0x01..0x04 in order.
REQ-041 rst_ni asserted during bit 3 of 0x77 with 2 bytes buffered -> fill_o=0 and valid_o=0 immediately; the next frame 0x12 is received correctly.
REQ-042 With UART_RX_PARITY_EN, frame 0x07 with a parity bit of 0 -> parity_err_o pulses once and no byte is pushed.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receive sink.
// The optional parity stage is enabled by defining UART_RX_PARITY_EN.
package uart_rx_pkg;

  localparam int CLK_DIV_DEFAULT = 868;
  localparam int DATA_BITS       = 8;

  typedef enum logic [2:0] {
    ST_ARM    = 3'd0,
    ST_IDLE   = 3'd1,
    ST_START  = 3'd2,
    ST_DATA   = 3'd3,
    ST_PARITY = 3'd4,
    ST_STOP   = 3'd5
  } state_e;

  // Even parity: the parity bit that makes the total number of ones even.
  function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Receive buffer for uart_rx_sink: power-of-two ring with occupancy count.
// A push into a full FIFO is accepted only when a pop happens in the same cycle.
module uart_rx_fifo
  import uart_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   push_i,
  input  logic [DATA_BITS-1:0]   data_i,
  input  logic                   pop_i,
  output logic [DATA_BITS-1:0]   data_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] fill_o
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_LVL = (AW + 1)'(DEPTH);

  logic [DATA_BITS-1:0] mem_q [DEPTH];
  logic [AW-1:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]        rd_ptr_q, rd_ptr_d;
  logic [AW:0]          fill_q, fill_d;
  logic                 do_push_s, do_pop_s;

  // Pointer and occupancy update; pointers wrap naturally at DEPTH.
  always_comb begin
    do_pop_s  = pop_i && (fill_q != '0);
    do_push_s = push_i && ((fill_q != FULL_LVL) || do_pop_s);
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    fill_d    = fill_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   fill_d = fill_q + 1'b1;
      2'b01:   fill_d = fill_q - 1'b1;
      default: fill_d = fill_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      fill_q   <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      fill_q   <= fill_d;
    end
  end

  // Storage array; contents are only visible through a non-empty head.
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= data_i;
    end
  end

  assign full_o  = (fill_q == FULL_LVL);
  assign empty_o = (fill_q == '0);
  assign fill_o  = fill_q;
  assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

endmodule

// File: rtl/uart_rx_sink.sv
// UART receiver (8 data bits, 1 stop bit) feeding a byte FIFO.
// Define UART_RX_PARITY_EN to add an even-parity bit after the data bits.
module uart_rx_sink
  import uart_rx_pkg::*;
#(
  parameter int CLK_DIV    = CLK_DIV_DEFAULT,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_ni,
  input  logic                        rx_i,
  output logic [DATA_BITS-1:0]        data_o,
  output logic                        valid_o,
  input  logic                        ready_i,
  output logic                        frame_err_o,
  output logic                        parity_err_o,
  output logic                        overrun_o,
  output logic [$clog2(FIFO_DEPTH):0] fill_o,
  output logic                        busy_o
);

  localparam logic [15:0] BIT_RELOAD = 16'(CLK_DIV - 1);
  localparam logic [15:0] HALF_BIT   = 16'(CLK_DIV / 2);
  localparam logic [2:0]  LAST_BIT   = 3'(DATA_BITS - 1);
`ifdef UART_RX_PARITY_EN
  localparam state_e      AFTER_DATA = ST_PARITY;
`else
  localparam state_e      AFTER_DATA = ST_STOP;
`endif

  state_e               state_q, state_d;
  logic                 sync1_q, sync2_q, rx_prev_q;
  logic [1:0]           settle_q;
  logic [15:0]          cnt_q, cnt_d;
  logic [2:0]           bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 par_bad_q, par_bad_d;
  logic                 frame_err_q, frame_err_d;
  logic                 parity_err_d;
  logic                 overrun_q, overrun_d;
  logic                 busy_q, busy_d;
  logic                 rx_s, in_frame_s, sample_s;
  logic                 push_s, pop_s, full_s, empty_s;

  assign rx_s       = sync2_q;
  assign in_frame_s = (state_q == ST_START) || (state_q == ST_DATA) ||
                      (state_q == ST_PARITY) || (state_q == ST_STOP);
  assign sample_s   = in_frame_s && (cnt_q == 16'd0);

  // State, synchronizer and datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_ARM;
      sync1_q     <= 1'b1;
      sync2_q     <= 1'b1;
      rx_prev_q   <= 1'b1;
      settle_q    <= 2'b00;
      cnt_q       <= 16'd0;
      bit_idx_q   <= 3'd0;
      shift_q     <= '0;
      par_bad_q   <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= rx_i;
      sync2_q     <= sync1_q;
      rx_prev_q   <= sync2_q;
      settle_q    <= {settle_q[0], 1'b1};
      cnt_q       <= cnt_d;
      bit_idx_q   <= bit_idx_d;
      shift_q     <= shift_d;
      par_bad_q   <= par_bad_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_q      <= busy_d;
    end
  end

  // Next-state and bit-timing logic.
  always_comb begin
    state_d   = state_q;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    par_bad_d = par_bad_q;
    if (sample_s) begin
      cnt_d = BIT_RELOAD;
    end else begin
      cnt_d = cnt_q - 16'd1;
    end
    case (state_q)
      ST_ARM: begin
        cnt_d = cnt_q;
        // Synchronizer reset values are not real line samples; wait for them to flush.
        if (settle_q[1] && rx_s) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_ARM;
        end
      end
      ST_IDLE: begin
        cnt_d = HALF_BIT;
        if (rx_prev_q && !rx_s) begin
          state_d = ST_START;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_START: begin
        if (sample_s) begin
          bit_idx_d = 3'd0;
          par_bad_d = 1'b0;
          state_d   = rx_s ? ST_IDLE : ST_DATA;
        end else begin
          state_d = ST_START;
        end
      end
      ST_DATA: begin
        if (sample_s) begin
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          bit_idx_d = bit_idx_q + 3'd1;
          state_d   = (bit_idx_q == LAST_BIT) ? AFTER_DATA : ST_DATA;
        end else begin
          state_d = ST_DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      ST_PARITY: begin
        if (sample_s) begin
          par_bad_d = (rx_s != even_parity(shift_q));
          state_d   = ST_STOP;
        end else begin
          state_d = ST_PARITY;
        end
      end
`endif
      ST_STOP: begin
        if (sample_s) begin
          state_d = rx_s ? ST_IDLE : ST_ARM;
        end else begin
          state_d = ST_STOP;
        end
      end
      default: begin
        cnt_d   = 16'd0;
        state_d = ST_ARM;
      end
    endcase
  end

  // Output decode: push strobe and registered status pulses.
  always_comb begin
    push_s       = 1'b0;
    frame_err_d  = 1'b0;
    parity_err_d = 1'b0;
    busy_d       = (state_d != ST_IDLE);
    if ((state_q == ST_STOP) && sample_s) begin
      push_s      = rx_s && !par_bad_q;
      frame_err_d = !rx_s;
    end else begin
      push_s      = 1'b0;
      frame_err_d = 1'b0;
    end
`ifdef UART_RX_PARITY_EN
    if ((state_q == ST_PARITY) && sample_s) begin
      parity_err_d = (rx_s != even_parity(shift_q));
    end else begin
      parity_err_d = 1'b0;
    end
`endif
    overrun_d = push_s && full_s && !pop_s;
  end

`ifdef UART_RX_PARITY_EN
  logic parity_err_q;

  // Parity error pulse register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      parity_err_q <= 1'b0;
    end else begin
      parity_err_q <= parity_err_d;
    end
  end

  assign parity_err_o = parity_err_q;
`else
  assign parity_err_o = 1'b0;
`endif

  assign pop_s = !empty_s && ready_i;

  uart_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push_s),
    .data_i  (shift_q),
    .pop_i   (pop_s),
    .data_o  (data_o),
    .full_o  (full_s),
    .empty_o (empty_s),
    .fill_o  (fill_o)
  );

  assign valid_o     = !empty_s;
  assign frame_err_o = frame_err_q;
  assign overrun_o   = overrun_q;
  assign busy_o      = busy_q;

endmodule

// File: tb/tb_uart_rx_sink.sv
// Self-checking bench for uart_rx_sink: directed scenarios plus random frames,
// checked against a byte-queue reference model.
module tb_uart_rx_sink;
  import uart_rx_pkg::*;

  localparam int CLK_DIV    = 16;
  localparam int FIFO_DEPTH = 4;
`ifdef UART_RX_PARITY_EN
  localparam int PBITS = 1;
`else
  localparam int PBITS = 0;
`endif
  localparam int FRAME_CYC = CLK_DIV * (DATA_BITS + PBITS + 2);
  // start bit driven -> 2 sync flops, edge detect, half-bit load, remaining bits, push
  localparam int RISE_LAT  = 4 + CLK_DIV / 2 + CLK_DIV * (DATA_BITS + PBITS + 1);

  logic       clk = 1'b0;
  logic       rst_ni, rx_i, ready_i;
  logic [7:0] data_o;
  logic       valid_o, frame_err_o, parity_err_o, overrun_o, busy_o;
  logic [2:0] fill_o;

  int checks = 0, failures = 0;
  int cyc = 0, n_pop = 0, n_ferr = 0, n_perr = 0, n_ovr = 0, extra_pops = 0;
  int b_pop, b_ferr, b_perr, b_ovr, b_extra;
  logic [7:0] exp_q[$];
  int         rise_q[$];
  logic       valid_prev = 1'b0, hold_prev = 1'b0, rst_prev = 1'b0;
  logic [7:0] data_prev = 8'd0;
  logic       rand_ready = 1'b0;

  uart_rx_sink #(
    .CLK_DIV    (CLK_DIV),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .clk_i        (clk),
    .rst_ni       (rst_ni),
    .rx_i         (rx_i),
    .data_o       (data_o),
    .valid_o      (valid_o),
    .ready_i      (ready_i),
    .frame_err_o  (frame_err_o),
    .parity_err_o (parity_err_o),
    .overrun_o    (overrun_o),
    .fill_o       (fill_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Monitor: scoreboard pops, count pulses, check hold stability.
  always @(negedge clk) begin
    if (rst_ni) begin
      if (valid_o && !valid_prev) rise_q.push_back(cyc);
      if (hold_prev && rst_prev) begin
        check_eq("hold_valid", 32'(valid_o), 32'd1);
        check_eq("hold_data", 32'(data_o), 32'(data_prev));
      end
      if (valid_o && ready_i) begin
        n_pop <= n_pop + 1;
        if (exp_q.size() != 0) check_eq("pop_data", 32'(data_o), 32'(exp_q.pop_front()));
        else extra_pops <= extra_pops + 1;
      end
      n_ferr <= n_ferr + int'(frame_err_o);
      n_perr <= n_perr + int'(parity_err_o);
      n_ovr  <= n_ovr + int'(overrun_o);
    end
    valid_prev <= valid_o;
    hold_prev  <= valid_o && !ready_i;
    data_prev  <= data_o;
    rst_prev   <= rst_ni;
  end

  initial forever begin
    @(posedge clk);
    #2;
    if (rand_ready) ready_i = 1'($urandom_range(0, 1));
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_bit(input logic v);
    rx_i = v;
    tick(CLK_DIV);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input logic par_ok);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par_ok ? ^b : ~^b);
`endif
    drive_bit(stop_v);
    rx_i = 1'b1;
  endtask

  // Reference model: a good frame lands in the buffer unless it is already full.
  int ovr_exp = 0;
  task automatic model_push(input logic [7:0] b);
    if (exp_q.size() >= FIFO_DEPTH) ovr_exp++;
    else exp_q.push_back(b);
  endtask

  task automatic scen_begin();
    b_pop = n_pop; b_ferr = n_ferr; b_perr = n_perr; b_ovr = n_ovr; b_extra = extra_pops;
  endtask

  task automatic scen_end(input string tag, input int pops, input int ferr, input int perr, input int ovr);
    check_eq({tag, "_pops"}, n_pop - b_pop, pops);
    check_eq({tag, "_ferr"}, n_ferr - b_ferr, ferr);
    check_eq({tag, "_perr"}, n_perr - b_perr, perr);
    check_eq({tag, "_ovr"}, n_ovr - b_ovr, ovr);
    check_eq({tag, "_extra"}, extra_pops - b_extra, 0);
    check_eq({tag, "_left"}, exp_q.size(), 0);
    check_eq({tag, "_fill"}, 32'(fill_o), 0);
    scen_begin();
  endtask

  initial begin
    int t0;
    logic [7:0] b;
    rst_ni = 1'b0; rx_i = 1'b1; ready_i = 1'b0;
    tick(3);
    check_eq("rst_valid", 32'(valid_o), 0);
    check_eq("rst_fill", 32'(fill_o), 0);
    check_eq("rst_busy", 32'(busy_o), 0);
    check_eq("rst_data", 32'(data_o), 0);
    check_eq("rst_errs", 32'({frame_err_o, parity_err_o, overrun_o}), 0);
    rst_ni = 1'b1;
    tick(5);
    check_eq("idle_busy", 32'(busy_o), 0);
    scen_begin();

    // Back-to-back frames with exact valid_o timing.
    ready_i = 1'b1;
    rise_q.delete();
    t0 = cyc;
    model_push(8'h55); send_frame(8'h55, 1'b1, 1'b1);
    model_push(8'hA3); send_frame(8'hA3, 1'b1, 1'b1);
    tick(20);
    check_eq("b2b_rises", rise_q.size(), 2);
    check_eq("b2b_rise0", rise_q.size() > 0 ? rise_q[0] : -1, t0 + RISE_LAT);
    check_eq("b2b_rise1", rise_q.size() > 1 ? rise_q[1] : -1, t0 + FRAME_CYC + RISE_LAT);
    scen_end("b2b", 2, 0, 0, 0);

    // False start glitch.
    rx_i = 1'b0; tick(5); rx_i = 1'b1; tick(3);
    check_eq("fs_busy_mid", 32'(busy_o), 1);
    tick(30);
    check_eq("fs_busy_end", 32'(busy_o), 0);
    scen_end("false_start", 0, 0, 0, 0);

    // Framing error followed by a line break, then a good frame.
    send_frame(8'h3C, 1'b0, 1'b1);
    rx_i = 1'b0; tick(200);
    rx_i = 1'b1; tick(20);
    model_push(8'h81); send_frame(8'h81, 1'b1, 1'b1);
    tick(20);
    scen_end("frame_err", 1, 1, 0, 0);

    // Overrun with consumer stalled.
    ready_i = 1'b0;
    ovr_exp = 0;
    for (int i = 1; i <= 4; i++) begin
      model_push(8'(i)); send_frame(8'(i), 1'b1, 1'b1);
    end
    tick(5);
    check_eq("ovr_none_yet", n_ovr - b_ovr, 0);
    model_push(8'h05); send_frame(8'h05, 1'b1, 1'b1);
    tick(5);
    check_eq("ovr_fill", 32'(fill_o), exp_q.size());
    check_eq("ovr_valid", 32'(valid_o), 1);
    check_eq("ovr_pulse", n_ovr - b_ovr, ovr_exp);
    ready_i = 1'b1;
    tick(20);
    scen_end("overrun", 4, 0, 0, 1);

    // Reset mid-frame with bytes buffered.
    ready_i = 1'b0;
    model_push(8'h10); send_frame(8'h10, 1'b1, 1'b1);
    model_push(8'h20); send_frame(8'h20, 1'b1, 1'b1);
    tick(5);
    check_eq("mid_fill2", 32'(fill_o), exp_q.size());
    b = 8'h77;
    drive_bit(1'b0);
    for (int i = 0; i < 3; i++) drive_bit(b[i]);
    rx_i = b[3];
    tick(CLK_DIV / 2);
    rst_ni = 1'b0;
    #1;
    check_eq("mid_rst_fill", 32'(fill_o), 0);
    check_eq("mid_rst_valid", 32'(valid_o), 0);
    check_eq("mid_rst_busy", 32'(busy_o), 0);
    exp_q.delete();
    tick(2);
    rx_i = 1'b1;
    rst_ni = 1'b1;
    tick(10);
    ready_i = 1'b1;
    scen_begin();
    model_push(8'h12); send_frame(8'h12, 1'b1, 1'b1);
    tick(20);
    scen_end("mid_rst", 1, 0, 0, 0);

    // Line held low across reset release.
    rx_i = 1'b0; rst_ni = 1'b0; tick(2);
    rst_ni = 1'b1; tick(50);
    check_eq("low_arm_busy", 32'(busy_o), 1);
    rx_i = 1'b1; tick(10);
    check_eq("low_idle_busy", 32'(busy_o), 0);
    scen_end("low_rst", 0, 0, 0, 0);

`ifdef UART_RX_PARITY_EN
    // Bad parity bit: byte discarded, stop bit still checked.
    send_frame(8'h07, 1'b1, 1'b0);
    tick(20);
    scen_end("parity", 0, 0, 1, 0);
`endif

    // Random frames with random idle gaps and a jittering consumer.
    rand_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      b = 8'($urandom);
      rx_i = 1'b1;
      tick($urandom_range(0, 40));
      model_push(b);
      send_frame(b, 1'b1, 1'b1);
    end
    tick(1);
    rand_ready = 1'b0;
    tick(1);
    ready_i = 1'b1;
    tick(30);
    scen_end("random", 24, 0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
